// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared definitions for the hardwired control sequencer.
//   - opcode constants (OP_ADD ... OP_HALT)
//   - 4-bit state encoding and the state enum built on it
//   - IR field bit positions (opcode, Ra, Rb, Rc)
//   - opcode class helpers used by the sequencer's decode
package cpu_defs;

  localparam int OPW   = 5;   // opcode field width
  localparam int RSELW = 4;   // register select field width
  localparam int NREG  = 16;  // general purpose registers R0..R15

  // IR field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  // Opcodes
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // State encoding
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH0 = 4'd1;
  localparam logic [3:0] ST_FETCH1 = 4'd2;
  localparam logic [3:0] ST_FETCH2 = 4'd3;
  localparam logic [3:0] ST_EXEC3  = 4'd4;
  localparam logic [3:0] ST_EXEC4  = 4'd5;
  localparam logic [3:0] ST_EXEC5  = 4'd6;
  localparam logic [3:0] ST_EXEC6  = 4'd7;
  localparam logic [3:0] ST_HALT   = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH0 = ST_FETCH0,
    S_FETCH1 = ST_FETCH1,
    S_FETCH2 = ST_FETCH2,
    S_EXEC3  = ST_EXEC3,
    S_EXEC4  = ST_EXEC4,
    S_EXEC5  = ST_EXEC5,
    S_EXEC6  = ST_EXEC6,
    S_HALT   = ST_HALT
  } state_t;

  // Three-step ALU instructions (result in Z low).
  function automatic logic is_alu(input logic [OPW-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                      OP_SHR, OP_SHL, OP_ROR, OP_ROL};
  endfunction

  // Four-step multiply/divide instructions (result split into LO/HI).
  function automatic logic is_md(input logic [OPW-1:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// reg_field_decoder: SELW-to-2**SELW one-hot decoder with enable.
//   sel    in   SELW      register number
//   en     in   1         when low, onehot is all zeros
//   onehot out  2**SELW   bit n set when en and sel == n
module reg_field_decoder
  import cpu_defs::*;
#(
  parameter int SELW = RSELW
) (
  input  logic [SELW-1:0]      sel,
  input  logic                 en,
  output logic [(1<<SELW)-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < (1 << SELW); gi++) begin : g_bit
      assign onehot[gi] = en && (sel == SELW'(gi));
    end
  endgenerate

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer driving the DataPath strobes.
// Steps FETCH0..FETCH2 then EXEC3..EXEC6 per instruction, decoding the
// instruction from the DataPath IR.
//   clock        in   rising-edge system clock
//   clear        in   asynchronous active-low reset (state -> IDLE)
//   ir           in   32-bit DataPath IR contents
//   stop         in   halt request, sampled in IDLE and an instruction's last state
//   PCout..IRin  out  fetch strobes
//   Yin..LOin    out  ALU / result strobes
//   Rin, Rout    out  one-hot GPR load / drive enables (bit n = Rn)
//   opcode       out  ALU operation, valid only in EXEC4 (else 0)
//   run          out  low only in HALT
//   instr_done   out  high in the last state of each instruction
module control_unit
  import cpu_defs::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             stop,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic [NREG-1:0]  Rin,
  output logic [NREG-1:0]  Rout,
  output logic [OPW-1:0]   opcode,
  output logic             run,
  output logic             instr_done
);

  state_t state_reg;

  logic [OPW-1:0]   ir_op;
  logic [RSELW-1:0] ra, rb, rc;
  logic             op_alu, op_md, op_halt;
  logic             unused_ir;

  assign ir_op   = ir[OP_MSB:OP_LSB];
  assign ra      = ir[RA_MSB:RA_LSB];
  assign rb      = ir[RB_MSB:RB_LSB];
  assign rc      = ir[RC_MSB:RC_LSB];
  assign op_alu  = is_alu(ir_op);
  assign op_md   = is_md(ir_op);
  assign op_halt = (ir_op == OP_HALT);
  assign unused_ir = ^ir[RC_LSB-1:0];

  // Where to go after an instruction's last state (and from IDLE).
  state_t after_instr;
  assign after_instr = stop ? S_HALT : S_FETCH0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:   state_reg <= after_instr;
        S_FETCH0: state_reg <= S_FETCH1;
        S_FETCH1: state_reg <= S_FETCH2;
        S_FETCH2: state_reg <= S_EXEC3;
        S_EXEC3: begin
          if (op_alu || op_md) state_reg <= S_EXEC4;
          else if (op_halt)    state_reg <= S_HALT;
          else                 state_reg <= after_instr;  // nop and unknown
        end
        S_EXEC4:  state_reg <= S_EXEC5;
        S_EXEC5:  state_reg <= op_md ? S_EXEC6 : after_instr;
        S_EXEC6:  state_reg <= after_instr;
        S_HALT:   state_reg <= S_HALT;                   // only clear leaves
        default:  state_reg <= S_IDLE;
      endcase
    end
  end

  // Register field selection: Rb is driven first (into Y), then Rc; the
  // result is written back to Ra only for the ALU class (MD goes to LO/HI).
  logic             rout_en, rin_en;
  logic [RSELW-1:0] rout_sel;

  assign rout_en  = (state_reg == S_EXEC3 || state_reg == S_EXEC4) && (op_alu || op_md);
  assign rout_sel = (state_reg == S_EXEC3) ? rb : rc;
  assign rin_en   = (state_reg == S_EXEC5) && op_alu;

  reg_field_decoder #(.SELW(RSELW)) u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_field_decoder #(.SELW(RSELW)) u_rin_dec (
    .sel    (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

  // Outputs depend only on state and the decoded IR, so reset clears them
  // immediately along with the state.
  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    opcode     = '0;
    instr_done = 1'b0;
    run        = (state_reg != S_HALT);
    case (state_reg)
      S_FETCH0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_FETCH1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_FETCH2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_EXEC3: begin
        if (op_alu || op_md) Yin = 1'b1;
        else                 instr_done = 1'b1;  // nop, unknown and halt end here
      end
      S_EXEC4: begin
        if (op_alu || op_md) begin
          Zin    = 1'b1;
          opcode = ir_op;
        end
      end
      S_EXEC5: begin
        if (op_alu) begin
          Zlowout    = 1'b1;
          instr_done = 1'b1;
        end else if (op_md) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
      end
      S_EXEC6: begin
        if (op_md) begin
          Zhighout   = 1'b1;
          HIin       = 1'b1;
          instr_done = 1'b1;
        end
      end
      default: begin
        instr_done = (ir_op == OP_NOP) && 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        stop;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  opcode;
  logic        run, instr_done;

  control_unit dut (
    .clock      (clock),
    .clear      (clear),
    .ir         (ir),
    .stop       (stop),
    .PCout      (PCout),
    .MARin      (MARin),
    .IncPC      (IncPC),
    .PCin       (PCin),
    .Read       (Read),
    .MDRin      (MDRin),
    .MDRout     (MDRout),
    .IRin       (IRin),
    .Yin        (Yin),
    .Zin        (Zin),
    .Zlowout    (Zlowout),
    .Zhighout   (Zhighout),
    .HIin       (HIin),
    .LOin       (LOin),
    .Rin        (Rin),
    .Rout       (Rout),
    .opcode     (opcode),
    .run        (run),
    .instr_done (instr_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;
    logic        run, instr_done;
  } outs_t;

  outs_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s val=%h", tag, got);
    end
  endtask

  function automatic outs_t sample();
    outs_t v;
    v = '{PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
          Yin, Zin, Zlowout, Zhighout, HIin, LOin, Rin, Rout, opcode,
          run, instr_done};
    return v;
  endfunction

  function automatic outs_t v_idle();
    outs_t v = '0;
    v.run = 1'b1;
    return v;
  endfunction

  function automatic outs_t v_halt();
    outs_t v = '0;
    return v;
  endfunction

  function automatic outs_t v_f0();
    outs_t v = v_idle();
    v.PCout = 1'b1; v.MARin = 1'b1; v.IncPC = 1'b1; v.Zin = 1'b1;
    return v;
  endfunction

  function automatic outs_t v_f1();
    outs_t v = v_idle();
    v.Zlowout = 1'b1; v.PCin = 1'b1; v.Read = 1'b1; v.MDRin = 1'b1;
    return v;
  endfunction

  function automatic outs_t v_f2();
    outs_t v = v_idle();
    v.MDRout = 1'b1; v.IRin = 1'b1;
    return v;
  endfunction

  function automatic outs_t v_e3(input logic [15:0] rout);
    outs_t v = v_idle();
    v.Rout = rout; v.Yin = 1'b1;
    return v;
  endfunction

  function automatic outs_t v_e4(input logic [15:0] rout, input logic [4:0] op);
    outs_t v = v_idle();
    v.Rout = rout; v.Zin = 1'b1; v.opcode = op;
    return v;
  endfunction

  function automatic outs_t v_done_only();
    outs_t v = v_idle();
    v.instr_done = 1'b1;
    return v;
  endfunction

  // Wait for the next falling edge and compare against the oldest expectation.
  task automatic step(input string tag);
    outs_t got, exp;
    @(negedge clock);
    got = sample();
    exp = exp_q.pop_front();
    check(tag, 64'(got), 64'(exp));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0) begin
      step($sformatf("%s[%0d]", tag, n));
      n++;
    end
  endtask

  // Fetch FETCH0 with the old IR still present, then present the new IR
  // (as DataPath would after its IR load) and queue the fetch remainder.
  task automatic start_instr(input string tag, input logic [31:0] instr);
    exp_q.push_back(v_f0());
    drain({tag, "_f0"});
    ir = instr;
    exp_q.push_back(v_f1());
    exp_q.push_back(v_f2());
  endtask

  initial begin
    outs_t v;
    clear = 1'b0;
    stop  = 1'b0;
    ir    = 32'h0;

    // Power-on reset
    exp_q.push_back(v_idle());
    exp_q.push_back(v_idle());
    drain("rst_hold");
    clear = 1'b1;
    exp_q.push_back(v_f0());
    exp_q.push_back(v_f1());
    drain("rst_release");

    // Asynchronous reset in the middle of FETCH1
    #2 clear = 1'b0;
    #1 check("async_rst", 64'(sample()), 64'(v_idle()));
    exp_q.push_back(v_idle());
    exp_q.push_back(v_idle());
    drain("rst_mid_f1");
    clear = 1'b1;

    // add r4,r3,r7
    start_instr("add", 32'h1A1B8000);
    exp_q.push_back(v_e3(16'h0008));
    exp_q.push_back(v_e4(16'h0080, 5'b00011));
    v = v_idle(); v.Zlowout = 1'b1; v.Rin = 16'h0010; v.instr_done = 1'b1;
    exp_q.push_back(v);
    drain("add");

    // mul r5,r6 (FETCH0 check also confirms the add returned to FETCH0)
    start_instr("mul", 32'h782B0000);
    exp_q.push_back(v_e3(16'h0020));
    exp_q.push_back(v_e4(16'h0040, 5'b01111));
    v = v_idle(); v.Zlowout = 1'b1; v.LOin = 1'b1;
    exp_q.push_back(v);
    v = v_idle(); v.Zhighout = 1'b1; v.HIin = 1'b1; v.instr_done = 1'b1;
    exp_q.push_back(v);
    drain("mul");

    // Unknown opcode behaves as nop
    start_instr("unk", 32'hF8000000);
    exp_q.push_back(v_done_only());
    drain("unk");

    // add with stop raised in EXEC4: completes, then HALT
    start_instr("add_stop", 32'h1A1B8000);
    exp_q.push_back(v_e3(16'h0008));
    exp_q.push_back(v_e4(16'h0080, 5'b00011));
    drain("add_stop");
    stop = 1'b1;
    v = v_idle(); v.Zlowout = 1'b1; v.Rin = 16'h0010; v.instr_done = 1'b1;
    exp_q.push_back(v);
    exp_q.push_back(v_halt());
    exp_q.push_back(v_halt());
    drain("add_stop_e5");

    // Recover with clear
    clear = 1'b0;
    stop  = 1'b0;
    #1 check("halt_clear", 64'(sample()), 64'(v_idle()));
    exp_q.push_back(v_idle());
    drain("halt_clear_hold");
    clear = 1'b1;

    // halt instruction: enters HALT after EXEC3 and stays there
    start_instr("halt", 32'hD8000000);
    exp_q.push_back(v_done_only());
    drain("halt");
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(v_halt());
      step($sformatf("halt_stay[%0d]", i));
      ir   = $urandom;
      stop = 1'($urandom_range(0, 1));
    end
    clear = 1'b0;
    stop  = 1'b0;
    #1 check("halt_instr_clear", 64'(sample()), 64'(v_idle()));
    exp_q.push_back(v_idle());
    drain("halt_instr_hold");
    clear = 1'b1;
    exp_q.push_back(v_f0());
    drain("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
